// File: rtl/stream_demux_1_4_pkg.sv
// Shared constants and helpers for the registered 1:4 stream demultiplexer.
package stream_demux_1_4_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef logic [SEL_W-1:0] sel_t;

  // Ceiling log2, usable in constant expressions for pointer/occupancy widths.
  function automatic int clog2(input int v);
    int r;
    r = 32'sd0;
    while ((32'sd1 << r) < v) begin
      r = r + 32'sd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/stream_demux_1_4_if.sv
// Producer-side and consumer-side handshake bundle of the 1:4 stream demux.
interface stream_demux_1_4_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
);
  import stream_demux_1_4_pkg::*;

  localparam int CW = clog2(DEPTH) + 1;

  logic                     in_valid;
  logic                     in_ready;
  sel_t                     in_sel;
  logic [DATA_W-1:0]        in_data;
  logic [NUM_CH-1:0]        out_valid;
  logic [NUM_CH-1:0]        out_ready;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic [NUM_CH*CW-1:0]     occ;

  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data, occ
  );

  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data, occ
  );

endinterface

// File: rtl/stream_demux_1_4_chan_fifo.sv
// Per-channel FIFO: registered storage, no input-to-output bypass, flush clears
// occupancy and pointers while leaving stale storage as harmless don't-care data.
module demux_chan_fifo
  import stream_demux_1_4_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2,
  parameter int CW     = clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_din,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_dout,
  output logic              o_valid,
  output logic              o_full,
  output logic [CW-1:0]     o_occ
);

  localparam int PW = clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_occ;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_occ == CW'(DEPTH));
  assign o_valid = (r_occ != {CW{1'b0}});
  assign o_dout  = r_mem[r_rd_ptr];
  assign o_occ   = r_occ;

  // Guard locally as well, so a full or flushing FIFO can never be corrupted.
  assign w_push = i_push & ~o_full & ~i_flush;
  assign w_pop  = i_pop & o_valid & ~i_flush;

  // Storage, pointers and occupancy; flush outranks push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {DATA_W{1'b0}};
      end
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_occ    <= {CW{1'b0}};
    end else if (i_flush) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_occ    <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + CW'(1);
        2'b01:   r_occ <= r_occ - CW'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

// File: rtl/stream_demux_1_4.sv
// Registered 1:4 stream demux: push decode, in_ready select and output packing
// around four independent channel FIFOs.
module stream_demux_1_4
  import stream_demux_1_4_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_flush,
  stream_demux_1_4_if.slave        bus
);

  localparam int CW = clog2(DEPTH) + 1;

  logic [NUM_CH-1:0] w_push;
  logic [NUM_CH-1:0] w_full;
  logic [DATA_W-1:0] w_dout [NUM_CH];
  logic [CW-1:0]     w_occ  [NUM_CH];
  logic              w_accept;

  // in_ready sees only the selected channel's full flag and flush, never out_ready.
  assign bus.in_ready = ~w_full[bus.in_sel] & ~i_flush;
  assign w_accept     = bus.in_valid & bus.in_ready;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign w_push[k] = w_accept & (bus.in_sel == SEL_W'(k));

    demux_chan_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .CW     (CW)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_flush (i_flush),
      .i_push  (w_push[k]),
      .i_din   (bus.in_data),
      .i_pop   (bus.out_ready[k]),
      .o_dout  (w_dout[k]),
      .o_valid (bus.out_valid[k]),
      .o_full  (w_full[k]),
      .o_occ   (w_occ[k])
    );

    assign bus.out_data[k*DATA_W +: DATA_W] = w_dout[k];
    assign bus.occ[k*CW +: CW]              = w_occ[k];
  end

endmodule

// File: tb/tb_stream_demux_1_4.sv
// Directed self-checking bench for stream_demux_1_4 (DATA_W=8, DEPTH=2).
module tb_stream_demux_1_4;

  logic clk;
  logic rst;
  logic flush;
  int   n_checks;
  int   n_fail;

  stream_demux_1_4_if #(.DATA_W(8), .DEPTH(2)) bus ();

  stream_demux_1_4 #(.DATA_W(8), .DEPTH(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_flush (flush),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] dout(input int k);
    return bus.out_data[k*8 +: 8];
  endfunction

  function automatic logic [1:0] occ(input int k);
    return bus.occ[k*2 +: 2];
  endfunction

  task automatic set_in(input logic v, input logic [1:0] s, input logic [7:0] d);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_sel   = s;
    bus.in_data  = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_v;
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sel    = 2'd0;
    bus.in_data   = 8'h00;
    bus.out_ready = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", 32'(bus.out_valid), 32'h0);
    check_eq("rst_occ",   32'(bus.occ),       32'h0);
    check_eq("rst_ready", 32'(bus.in_ready),  32'h1);
    check_eq("rst_data",  32'(bus.out_data),  32'h0);
    @(negedge clk);
    rst = 1'b0;

    // 1: asynchronous reset mid-cycle discards a stored word immediately
    set_in(1'b1, 2'd0, 8'h5A);
    step();
    check_eq("pre_rst_valid", 32'(bus.out_valid), 32'h1);
    set_in(1'b0, 2'd0, 8'h00);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_valid", 32'(bus.out_valid), 32'h0);
    check_eq("arst_occ",   32'(bus.occ),       32'h0);
    check_eq("arst_ready", 32'(bus.in_ready),  32'h1);
    check_eq("arst_data",  32'(dout(0)),       32'h0);
    #1 rst = 1'b0;

    // 2: one word per channel with all consumers ready
    bus.out_ready = 4'hF;
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, 2'(k), 8'hA0 + 8'(k));
      #1;
      check_eq("pass_ready", 32'(bus.in_ready), 32'h1);
      step();
      exp_v = 4'(4'b0001 << k);
      check_eq("pass_valid", 32'(bus.out_valid), 32'(exp_v));
      check_eq("pass_data",  32'(dout(k)),       32'hA0 + 32'(k));
    end
    set_in(1'b0, 2'd0, 8'h00);
    step();
    check_eq("pass_drain", 32'(bus.out_valid), 32'h0);

    // 3: fill ch2, third push stalls, ch1 still accepted
    bus.out_ready = 4'h0;
    set_in(1'b1, 2'd2, 8'h11);
    step();
    set_in(1'b1, 2'd2, 8'h22);
    step();
    check_eq("fill_occ2", 32'(occ(2)), 32'h2);
    set_in(1'b1, 2'd2, 8'h33);
    #1;
    check_eq("full_ready", 32'(bus.in_ready), 32'h0);
    step();
    check_eq("full_occ2", 32'(occ(2)), 32'h2);
    check_eq("full_head2", 32'(dout(2)), 32'h11);
    set_in(1'b1, 2'd1, 8'h44);
    #1;
    check_eq("other_ready", 32'(bus.in_ready), 32'h1);
    step();
    check_eq("other_occ1",  32'(occ(1)),  32'h1);
    check_eq("other_data1", 32'(dout(1)), 32'h44);

    // 4: pop on full ch2 does not admit the pending push in the same cycle
    set_in(1'b1, 2'd2, 8'h55);
    bus.out_ready = 4'b0100;
    #1;
    check_eq("popfull_ready", 32'(bus.in_ready), 32'h0);
    step();
    check_eq("popfull_occ2",  32'(occ(2)),  32'h1);
    check_eq("popfull_head2", 32'(dout(2)), 32'h22);
    @(negedge clk);
    #1;
    check_eq("retry_ready", 32'(bus.in_ready), 32'h1);
    step();
    check_eq("retry_occ2",  32'(occ(2)),  32'h1);
    check_eq("retry_head2", 32'(dout(2)), 32'h55);
    set_in(1'b0, 2'd0, 8'h00);
    step();
    check_eq("drain_occ2",   32'(occ(2)),           32'h0);
    check_eq("drain_valid2", 32'(bus.out_valid[2]), 32'h0);

    // 5: simultaneous push and pop on ch0 holding one word
    bus.out_ready = 4'h0;
    set_in(1'b1, 2'd0, 8'h66);
    step();
    check_eq("pp_pre_occ0", 32'(occ(0)), 32'h1);
    set_in(1'b1, 2'd0, 8'h77);
    bus.out_ready = 4'b0001;
    #1;
    check_eq("pp_ready", 32'(bus.in_ready), 32'h1);
    step();
    check_eq("pp_occ0",  32'(occ(0)),  32'h1);
    check_eq("pp_head0", 32'(dout(0)), 32'h77);

    // 6: flush wins over a valid input and clears every channel
    bus.out_ready = 4'h0;
    set_in(1'b1, 2'd0, 8'h88);
    step();
    check_eq("f_occ0", 32'(occ(0)), 32'h2);
    set_in(1'b1, 2'd3, 8'h99);
    step();
    set_in(1'b1, 2'd3, 8'h9A);
    step();
    check_eq("f_occ3", 32'(occ(3)), 32'h2);
    set_in(1'b1, 2'd1, 8'hBB);
    flush = 1'b1;
    #1;
    check_eq("flush_ready", 32'(bus.in_ready), 32'h0);
    step();
    check_eq("flush_occ",   32'(bus.occ),       32'h0);
    check_eq("flush_valid", 32'(bus.out_valid), 32'h0);
    @(negedge clk);
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check_eq("post_ready", 32'(bus.in_ready), 32'h1);
    step();
    check_eq("post_occ",   32'(bus.occ),       32'h0);
    check_eq("post_valid", 32'(bus.out_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
